// File: rtl/rst_pulse_gen.sv
// rst_pulse_gen
// Turns a one-cycle reset request into a clean, registered reset level held for
// HOLD_CYCLES cycles. It then waits GUARD_CYCLES cycles, ignoring requests,
// before re-arming. A one-cycle done pulse marks each completed sequence.
module rst_pulse_gen #(
    parameter int HOLD_CYCLES  = 100,
    parameter int GUARD_CYCLES = 16,
    parameter bit RETRIGGER    = 1'b0,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic rst_out,
    output logic busy,
    output logic done
);

    // The single counter serves both the hold and the guard phase, so it must
    // reach the larger of the two terminal values.
    localparam int MAX_CNT = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

    // Refuse to build with a zero-length hold or a counter too narrow to count it.
    generate
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("rst_pulse_gen: HOLD_CYCLES must be at least 1");
        end
        if (GUARD_CYCLES < 0) begin : g_bad_guard
            $error("rst_pulse_gen: GUARD_CYCLES must not be negative");
        end
        if (CNT_W < 1 || CNT_W < $clog2(MAX_CNT)) begin : g_bad_width
            $error("rst_pulse_gen: CNT_W too small for max(HOLD_CYCLES,GUARD_CYCLES)-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_done;

    // State and counter register; reset abandons any sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: the counter is compared against the terminal value and
    // cleared on every phase change, so it never wraps.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    next_state = ST_ASSERT;
                    next_cnt   = '0;
                end
            end
            ST_ASSERT: begin
                if (RETRIGGER && trig) begin
                    next_cnt = '0;
                end else if (cnt == HOLD_LAST) begin
                    next_cnt = '0;
                    if (GUARD_CYCLES > 0) begin
                        next_state = ST_GUARD;
                    end else begin
                        next_state = ST_IDLE;
                        next_done  = 1'b1;
                    end
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                    next_done  = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // together with the state and are glitch-free downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            rst_out <= (next_state == ST_ASSERT);
            busy    <= (next_state != ST_IDLE);
            done    <= next_done;
        end
    end

endmodule
